// File: rtl/trdb_branch_map_unpacker.sv
// trdb_branch_map_unpacker
//   Decoder-side replay of a packed branch map. A map of up to MAP_LEN
//   taken/not-taken bits is loaded through a valid/ready handshake. The bits
//   are then replayed one per accepted beat, oldest (bit 0) first.
//
// Ports
//   clk_i, rst_i       clock (rising edge), asynchronous active-high reset
//   in_valid_i/ready_o load handshake for map_i / branches_i
//   map_i              packed map, bit 0 oldest, 1 = taken
//   branches_i         number of valid bits in map_i (0..MAP_LEN)
//   flush_i            drop the current map; no load accepted this cycle
//   bit_valid_o/ready_i per-bit handshake towards the consumer
//   bit_taken_o        current branch outcome
//   bit_last_o         current bit is the final bit of the map
//   remaining_o        bits not yet consumed, including the current one
//   busy_o             a map is being unpacked
module trdb_branch_map_unpacker #(
    parameter int MAP_LEN = 31,
    localparam int CNT_W  = $clog2(MAP_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [MAP_LEN-1:0] map_i,
    input  logic [CNT_W-1:0]   branches_i,
    input  logic               flush_i,
    output logic               bit_valid_o,
    output logic               bit_taken_o,
    output logic               bit_last_o,
    input  logic               bit_ready_i,
    output logic [CNT_W-1:0]   remaining_o,
    output logic               busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [MAP_LEN-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;

    logic               last_q;
    logic               load;
    logic               xfer;
    logic [MAP_LEN-1:0] map_masked;

    assign busy_o      = (state_q == SHIFT);
    assign bit_valid_o = busy_o;
    assign bit_taken_o = shift_q[0];
    assign remaining_o = rem_q;
    assign last_q      = busy_o & (rem_q == CNT_W'(1));
    assign bit_last_o  = last_q;

    // Ready is gated by rst_i so nothing can be accepted while reset is held.
    // Accepting on the edge that consumes the last bit gives bubble-free
    // back-to-back maps.
    assign in_ready_o = ~rst_i & ~flush_i &
                        ((state_q == IDLE) | (bit_ready_i & last_q));

    assign load = in_valid_i & in_ready_o;
    assign xfer = bit_valid_o & bit_ready_i;

    // Bits beyond the branch count are cleared on load, so they can never
    // reach bit_taken_o, not even while idle after the map drains.
    always_comb begin
        map_masked = '0;
        for (int i = 0; i < MAP_LEN; i++) begin
            map_masked[i] = map_i[i] & (CNT_W'(i) < branches_i);
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        if (flush_i) begin
            state_d = IDLE;
            shift_d = '0;
            rem_d   = '0;
        end else if (load) begin
            // load implies IDLE or last-bit transfer, so the old map is done
            if (branches_i != '0) begin
                state_d = SHIFT;
                shift_d = map_masked;
                rem_d   = branches_i;
            end else begin
                state_d = IDLE;
                shift_d = '0;
                rem_d   = '0;
            end
        end else if (xfer) begin
            shift_d = {1'b0, shift_q[MAP_LEN-1:1]};
            rem_d   = rem_q - CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? IDLE : SHIFT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
        end
    end

endmodule
